dual_source_arbiter: RTL and testbench
======================================

Name: dual_source_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4-bit two-input switching datapath, which passes input 1 when its select is 0 and input 2 when its select is 1.
- Two requesters compete for the shared output. The block grants one requester at a time for a bounded number of cycles and drives the select line.
- It registers the selected data onto a shared output with a valid flag.
- It sits between the requesters and the downstream consumer of the switched bus.

Parameters:
- WIDTH, 4, data width of IN_1, IN_2 and OUT.
- HOLD, 3, maximum data cycles per grant; legal range 1..15.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- REQ_1  input  1  request from source 1.
- REQ_2  input  1  request from source 2.
- IN_1  input  WIDTH  data from source 1.
- IN_2  input  WIDTH  data from source 2.
- GNT_1  output  1  registered grant to source 1.
- GNT_2  output  1  registered grant to source 2.
- SEL  output  1  switching select: 0 selects source 1, 1 selects source 2.
- OUT  output  WIDTH  registered shared output data.
- VALID  output  1  OUT carries data captured at the last edge.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values: state IDLE, GNT_1=0, GNT_2=0, SEL=0, OUT=0, VALID=0, count=0, last_served=2 (so source 1 wins the first tie).
- States: IDLE, GRANT_1, GRANT_2, one-hot or binary.
  - GNT_1 is 1 iff state is GRANT_1; GNT_2 is 1 iff state is GRANT_2.
  - SEL is 1 in GRANT_2 and 0 in GRANT_1. In IDLE, SEL holds its last value.
- IDLE, at each edge:
  - Only REQ_1=1 -> GRANT_1.
  - Only REQ_2=1 -> GRANT_2.
  - Both requesting -> grant the source that is not last_served.
  - On entering a grant, count <= HOLD-1.
  - VALID <= 0; OUT holds.
  - Grant appears one cycle after the request is sampled.
- GRANT_x, at each edge, when REQ_x=1:
  - OUT <= IN_x and VALID <= 1.
  - If count != 0: count <= count-1 and stay.
  - If count == 0: release.
- GRANT_x, at each edge, when REQ_x=0 (early release):
  - VALID <= 0, OUT holds, release immediately.
- Release from GRANT_x:
  - last_served <= x.
  - Other REQ=1 -> enter GRANT_other with count <= HOLD-1. No IDLE bubble; VALID may stay high across the switch.
  - Else REQ_x=1 -> re-enter GRANT_x with count reloaded.
  - Else -> IDLE.
- Each grant yields at most HOLD captures. A requester continuously contended waits at most HOLD cycles after its rival is granted.
- Data path: OUT only changes on captures, with one-cycle latency from IN_x sampled at the edge. No combinational path from IN_x or REQ_x to any output.
- Boundary cases:
  - HOLD=1 with both requesting: grants alternate every cycle.
  - Simultaneous release and rival request: the rival is granted at the same edge.
  - Data changing mid-grant: captured each cycle, with no latching of the first value.
- Reset mid-grant: all outputs return to reset values immediately (asynchronous). Arbitration restarts with source 1 preferred.

Test Plan:
1. RST pulse while in GRANT_2 with VALID=1 -> GNT_2, VALID, OUT and SEL drop to 0 before the next edge. The next tie grants source 1.
2. REQ_1=1 held, REQ_2=0, IN_1=4'hA, HOLD=3:
   - GNT_1=1 from edge 1 onward, with continuous re-grant.
   - VALID=1 and OUT=4'hA from edge 2; SEL=0 throughout.
3. REQ_1=REQ_2=1 from reset, IN_1=4'h3, IN_2=4'hC, HOLD=3:
   - OUT=3 for 3 cycles, then OUT=C for 3 cycles, repeating.
   - VALID stays 1 with no gap. SEL toggles 0->1 at the edge where GNT_2 rises.
4. GRANT_1 active, REQ_1 dropped after 1 capture, REQ_2=1 -> next edge: GNT_2=1, VALID=0 for that cycle, then OUT=IN_2.
5. HOLD=1, both requesting -> GNT_1/GNT_2 alternate every cycle; OUT alternates IN_1/IN_2.
6. Both requests dropped during GRANT_2 -> IDLE at the next edge: VALID=0, OUT and SEL=1 hold. A later tie grants source 1.

Source files
------------

// File: rtl/dual_source_arbiter.sv
// dual_source_arbiter: round-robin grant and select sequencer for a shared two-input switched bus,
// registering the selected source onto OUT with a valid flag and a bounded hold per grant.
module dual_source_arbiter #(
   parameter int WIDTH = 4,
   parameter int HOLD  = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ_1,
   input  logic             REQ_2,
   input  logic [WIDTH-1:0] IN_1,
   input  logic [WIDTH-1:0] IN_2,
   output logic             GNT_1,
   output logic             GNT_2,
   output logic             SEL,
   output logic [WIDTH-1:0] OUT,
   output logic             VALID
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_G1   = 2'd1;
   localparam logic [1:0] S_G2   = 2'd2;
   localparam logic [3:0] RELOAD = 4'(HOLD - 1);

   logic [1:0]       state_q, state_d;
   logic [3:0]       count_q, count_d;
   logic             last_q, last_d;
   logic             sel_q, sel_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             g1, g2, req_cur, req_oth, rel, pick1;

   assign g1      = state_q == S_G1;
   assign g2      = state_q == S_G2;
   assign req_cur = g2 ? REQ_2 : REQ_1;
   assign req_oth = g2 ? REQ_1 : REQ_2;
   assign rel     = (g1 | g2) & (~req_cur | count_q == 4'd0);
   // last_q=1 means source 2 was served last, so source 1 wins a tie
   assign pick1   = REQ_1 & (~REQ_2 | last_q);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      last_d  = last_q;
      out_d   = out_q;
      valid_d = 1'b0;
      if (!(g1 | g2)) begin
         state_d = pick1 ? S_G1 : REQ_2 ? S_G2 : S_IDLE;
         count_d = (REQ_1 | REQ_2) ? RELOAD : count_q;
      end else begin
         if (req_cur) begin
            out_d   = g2 ? IN_2 : IN_1;
            valid_d = 1'b1;
            count_d = count_q - 4'd1;
         end
         if (rel) begin
            last_d  = g2;
            state_d = req_oth ? (g2 ? S_G1 : S_G2) : req_cur ? state_q : S_IDLE;
            count_d = RELOAD;
         end
      end
      sel_d = state_d == S_G2 ? 1'b1 : state_d == S_G1 ? 1'b0 : sel_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         count_q <= 4'd0;
         last_q  <= 1'b1;
         sel_q   <= 1'b0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         out_q   <= out_d;
      end
   end

   assign GNT_1 = g1;
   assign GNT_2 = g2;
   assign SEL   = sel_q;
   assign OUT   = out_q;
   assign VALID = valid_q;
endmodule

// File: tb/tb_dual_source_arbiter.sv
// tb_dual_source_arbiter: directed scoreboard bench; HOLD=3 and HOLD=1 instances share all inputs.
module tb_dual_source_arbiter;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       REQ_1 = 1'b0, REQ_2 = 1'b0;
   logic [3:0] IN_1 = 4'h0, IN_2 = 4'h0;
   logic       g1_a, g2_a, sel_a, v_a, g1_b, g2_b, sel_b, v_b;
   logic [3:0] out_a, out_b;
   int         errors = 0;
   int         checks = 0;

   typedef struct {
      string      tag;
      bit         w;
      logic [7:0] e;
   } exp_t;
   exp_t sb[$];

   dual_source_arbiter #(.WIDTH(4), .HOLD(3)) dut (
      .CLK(CLK), .RST(RST), .REQ_1(REQ_1), .REQ_2(REQ_2), .IN_1(IN_1), .IN_2(IN_2),
      .GNT_1(g1_a), .GNT_2(g2_a), .SEL(sel_a), .OUT(out_a), .VALID(v_a)
   );

   dual_source_arbiter #(.WIDTH(4), .HOLD(1)) dut1 (
      .CLK(CLK), .RST(RST), .REQ_1(REQ_1), .REQ_2(REQ_2), .IN_1(IN_1), .IN_2(IN_2),
      .GNT_1(g1_b), .GNT_2(g2_b), .SEL(sel_b), .OUT(out_b), .VALID(v_b)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] pk(input logic g1, g2, s, v, input logic [3:0] o);
      return {g1, g2, s, v, o};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] e);
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed={g1,g2,sel,valid,out}=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic step(input logic r1, r2, input logic [3:0] a, b, input bit w,
                       input logic [7:0] e, input string tag);
      exp_t x;
      REQ_1 = r1;
      REQ_2 = r2;
      IN_1  = a;
      IN_2  = b;
      sb.push_back('{tag, w, e});
      @(posedge CLK);
      #1;
      x = sb.pop_front();
      chk(x.tag, x.w ? {g1_b, g2_b, sel_b, v_b, out_b} : {g1_a, g2_a, sel_a, v_a, out_a}, x.e);
   endtask

   task automatic pulse_rst();
      RST = 1'b1;
      #1;
      chk("rst_async", {g1_a, g2_a, sel_a, v_a, out_a}, 8'h00);
      RST = 1'b0;
   endtask

   initial begin
      #2;
      chk("reset_state", {g1_a, g2_a, sel_a, v_a, out_a}, 8'h00);
      chk("reset_state_h1", {g1_b, g2_b, sel_b, v_b, out_b}, 8'h00);
      #10 RST = 1'b0;
      // single requester, continuous re-grant, data change mid-grant
      step(1, 0, 4'hA, 4'h0, 0, pk(1, 0, 0, 0, 4'h0), "solo_e1");
      step(1, 0, 4'hA, 4'h0, 0, pk(1, 0, 0, 1, 4'hA), "solo_e2");
      step(1, 0, 4'hA, 4'h0, 0, pk(1, 0, 0, 1, 4'hA), "solo_e3");
      step(1, 0, 4'hA, 4'h0, 0, pk(1, 0, 0, 1, 4'hA), "solo_regrant");
      step(1, 0, 4'h5, 4'h0, 0, pk(1, 0, 0, 1, 4'h5), "solo_datachg");
      step(0, 0, 4'h5, 4'h0, 0, pk(0, 0, 0, 0, 4'h5), "solo_drop");
      #3 pulse_rst();
      // both requesting, HOLD=3 round robin
      step(1, 1, 4'h3, 4'hC, 0, pk(1, 0, 0, 0, 4'h0), "rr_e1");
      step(1, 1, 4'h3, 4'hC, 0, pk(1, 0, 0, 1, 4'h3), "rr_e2");
      step(1, 1, 4'h3, 4'hC, 0, pk(1, 0, 0, 1, 4'h3), "rr_e3");
      step(1, 1, 4'h3, 4'hC, 0, pk(0, 1, 1, 1, 4'h3), "rr_switch2");
      step(1, 1, 4'h3, 4'hC, 0, pk(0, 1, 1, 1, 4'hC), "rr_e5");
      step(1, 1, 4'h3, 4'hC, 0, pk(0, 1, 1, 1, 4'hC), "rr_e6");
      step(1, 1, 4'h3, 4'hC, 0, pk(1, 0, 0, 1, 4'hC), "rr_switch1");
      step(1, 1, 4'h3, 4'hC, 0, pk(1, 0, 0, 1, 4'h3), "rr_e8");
      // early release of source 1 with source 2 waiting
      step(0, 1, 4'h3, 4'h5, 0, pk(0, 1, 1, 0, 4'h3), "early_rel");
      step(0, 1, 4'h3, 4'h5, 0, pk(0, 1, 1, 1, 4'h5), "early_cap2");
      // async reset while GRANT_2 with VALID=1, then tie goes to source 1
      #3 pulse_rst();
      step(1, 1, 4'h3, 4'hC, 0, pk(1, 0, 0, 0, 4'h0), "post_rst_tie");
      step(1, 1, 4'h3, 4'hC, 0, pk(1, 0, 0, 1, 4'h3), "f2");
      step(1, 1, 4'h3, 4'hC, 0, pk(1, 0, 0, 1, 4'h3), "f3");
      step(1, 1, 4'h3, 4'hC, 0, pk(0, 1, 1, 1, 4'h3), "f4_to_g2");
      // both drop during GRANT_2: idle holds SEL and OUT
      step(0, 0, 4'h3, 4'hC, 0, pk(0, 0, 1, 0, 4'h3), "drop_idle");
      step(1, 1, 4'h3, 4'hC, 0, pk(1, 0, 0, 0, 4'h3), "idle_tie_src1");
      step(0, 0, 4'h3, 4'hC, 0, pk(0, 0, 0, 0, 4'h3), "idle_again");
      #3 pulse_rst();
      // HOLD=1 instance alternates every cycle
      step(1, 1, 4'h6, 4'h9, 1, pk(1, 0, 0, 0, 4'h0), "h1_e1");
      step(1, 1, 4'h6, 4'h9, 1, pk(0, 1, 1, 1, 4'h6), "h1_e2");
      step(1, 1, 4'h6, 4'h9, 1, pk(1, 0, 0, 1, 4'h9), "h1_e3");
      step(1, 1, 4'h6, 4'h9, 1, pk(0, 1, 1, 1, 4'h6), "h1_e4");
      step(1, 1, 4'h6, 4'h9, 1, pk(1, 0, 0, 1, 4'h9), "h1_e5");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
